// File: rtl/truth_table_sweeper.sv
// Sweeps every input row of two minterm-mask functions, one row per handshake,
// and reports equivalence, the mismatch count and the first mismatching row.
module truth_table_sweeper #(
    parameter int N_IN = 3,
    parameter bit GRAY = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   mask_a,
    input  logic [(1<<N_IN)-1:0]   mask_b,
    input  logic                   row_ready,
    output logic                   busy,
    output logic                   row_valid,
    output logic [N_IN-1:0]        row_idx,
    output logic                   row_a,
    output logic                   row_b,
    output logic                   row_mismatch,
    output logic                   done,
    output logic                   equivalent,
    output logic [N_IN:0]          mismatch_count,
    output logic [N_IN-1:0]        first_mismatch
);

    localparam int M = 1 << N_IN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN:0]     step_q, step_d;
    logic [M-1:0]      ma_q, ma_d;
    logic [M-1:0]      mb_q, mb_d;
    logic [N_IN:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]   first_q, first_d;
    logic              eq_q, eq_d;

    logic [N_IN-1:0]   bin_idx;
    logic [N_IN-1:0]   cur_idx;
    logic              cur_mm;
    logic              sweeping;
    logic              xfer;
    logic              last;

    assign bin_idx  = step_q[N_IN-1:0];
    assign cur_idx  = GRAY ? (bin_idx ^ (bin_idx >> 1)) : bin_idx;
    assign cur_mm   = ma_q[cur_idx] ^ mb_q[cur_idx];
    assign sweeping = (state_q == SWEEP);
    assign xfer     = sweeping & row_ready;
    assign last     = (step_q == (N_IN+1)'(M - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SWEEP;
            SWEEP:   if (xfer && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: masks are captured only on an accepted start.
    always_comb begin
        step_d  = step_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        eq_d    = eq_q;
        if (state_q == IDLE && start) begin
            ma_d    = mask_a;
            mb_d    = mask_b;
            step_d  = '0;
            cnt_d   = '0;
            first_d = '0;
            eq_d    = 1'b0;
        end else if (xfer) begin
            if (cur_mm) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) first_d = cur_idx;
            end
            if (last) eq_d = (cnt_d == '0);
            else      step_d = step_q + 1'b1;
        end
    end

    always_comb begin
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        row_valid    = sweeping;
        row_idx      = sweeping ? cur_idx : '0;
        row_a        = sweeping & ma_q[cur_idx];
        row_b        = sweeping & mb_q[cur_idx];
        row_mismatch = sweeping & cur_mm;
    end

    assign equivalent     = eq_q;
    assign mismatch_count = cnt_q;
    assign first_mismatch = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: four instances (N_IN=3 binary, N_IN=3 Gray,
// N_IN=1, N_IN=6) driven from a vector table and random masks.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        st[4];
    logic        rdy[4];
    logic [63:0] ma[4];
    logic [63:0] mb[4];
    logic        bsy[4];
    logic        rv[4];
    logic        ra[4];
    logic        rb[4];
    logic        rm[4];
    logic        dn[4];
    logic        eq[4];
    logic [5:0]  ri[4];
    logic [5:0]  fm[4];
    logic [6:0]  mc[4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int N = (g == 2) ? 1 : (g == 3) ? 6 : 3;
        localparam bit G = (g == 1);
        logic [N-1:0] ri_l;
        logic [N-1:0] fm_l;
        logic [N:0]   mc_l;
        truth_table_sweeper #(.N_IN(N), .GRAY(G)) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (st[g]),
            .mask_a         (ma[g][(1<<N)-1:0]),
            .mask_b         (mb[g][(1<<N)-1:0]),
            .row_ready      (rdy[g]),
            .busy           (bsy[g]),
            .row_valid      (rv[g]),
            .row_idx        (ri_l),
            .row_a          (ra[g]),
            .row_b          (rb[g]),
            .row_mismatch   (rm[g]),
            .done           (dn[g]),
            .equivalent     (eq[g]),
            .mismatch_count (mc_l),
            .first_mismatch (fm_l)
        );
        assign ri[g] = 6'(ri_l);
        assign fm[g] = 6'(fm_l);
        assign mc[g] = 7'(mc_l);
    end

    int nvec = 0;
    int nfail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int nof(int g);
        return (g == 2) ? 1 : (g == 3) ? 6 : 3;
    endfunction

    // Sweep order: the i-th row visited, straight from the ordering rule.
    function automatic int ord(int g, int i);
        return (g == 1) ? (i ^ (i >> 1)) : i;
    endfunction

    task automatic sweep(int g, logic [63:0] a, logic [63:0] b,
                         int srow, int sn, bit mid,
                         int e_cnt, int e_first);
        int rows;
        logic [63:0] am, bm, keep;
        int mcnt, mfirst, xcnt, xfirst;
        int k, stalled, cyc, vcyc, idx;
        bit found;
        rows = 1 << nof(g);
        keep = (rows == 64) ? '1 : ((64'd1 << rows) - 1);
        am = a & keep;
        bm = b & keep;
        mcnt = $countones(am ^ bm);
        mfirst = 0;
        found = 0;
        for (int i = 0; i < rows; i++) begin
            idx = ord(g, i);
            if (!found && (am[idx] ^ bm[idx])) begin
                mfirst = idx;
                found = 1;
            end
        end
        xcnt   = (e_cnt >= 0) ? e_cnt : mcnt;
        xfirst = (e_first >= 0) ? e_first : mfirst;

        @(negedge clk);
        ma[g] = a; mb[g] = b; st[g] = 1'b1; rdy[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0;
        k = 0; stalled = 0; cyc = 0; vcyc = 0;
        while (dn[g] !== 1'b1) begin
            if (cyc > rows + sn + 4) begin
                chk("done_timeout", 0, 1);
                break;
            end
            idx = ord(g, k);
            chk("row_valid", rv[g], 1);
            chk("busy", bsy[g], 1);
            chk("row_idx", ri[g], idx);
            chk("row_a", ra[g], am[idx]);
            chk("row_b", rb[g], bm[idx]);
            chk("row_mm", rm[g], am[idx] ^ bm[idx]);
            vcyc++;
            if (mid) begin
                st[g] = (k == 2);
                if (k == 2) mb[g] = ~b;
            end
            if (k == srow && stalled < sn) begin
                rdy[g] = 1'b0;
                stalled++;
            end else begin
                rdy[g] = 1'b1;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        st[g] = 1'b0;
        rdy[g] = 1'b1;
        chk("rows_seen", k, rows);
        chk("valid_cycles", vcyc, rows + stalled);
        chk("done_busy", bsy[g], 1);
        chk("done_valid", rv[g], 0);
        chk("count", mc[g], xcnt);
        chk("first", fm[g], xfirst);
        chk("equiv", eq[g], (xcnt == 0));
        @(negedge clk);
        chk("done_pulse", dn[g], 0);
        chk("idle_busy", bsy[g], 0);
        chk("hold_count", mc[g], xcnt);
        chk("hold_equiv", eq[g], (xcnt == 0));
    endtask

    task automatic chk_zero(int g);
        chk("rst_busy", bsy[g], 0);
        chk("rst_valid", rv[g], 0);
        chk("rst_idx", ri[g], 0);
        chk("rst_a", ra[g], 0);
        chk("rst_b", rb[g], 0);
        chk("rst_mm", rm[g], 0);
        chk("rst_done", dn[g], 0);
        chk("rst_equiv", eq[g], 0);
        chk("rst_count", mc[g], 0);
        chk("rst_first", fm[g], 0);
    endtask

    typedef struct {
        int          g;
        logic [63:0] a;
        logic [63:0] b;
        int          srow;
        int          sn;
        bit          mid;
        int          cnt;
        int          first;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{0, 64'h8A, 64'h8A, 99, 0, 1'b0, 0, 0};
        tbl[1] = '{0, 64'h8A, 64'h8B, 99, 0, 1'b0, 1, 0};
        tbl[2] = '{0, 64'h8A, 64'h0A, 2, 3, 1'b0, 1, 7};
        tbl[3] = '{1, 64'h8A, 64'hC2, 99, 0, 1'b0, 2, 3};
        tbl[4] = '{0, 64'h8A, 64'h8A, 99, 0, 1'b1, 0, 0};
        tbl[5] = '{2, 64'h2, 64'h3, 99, 0, 1'b0, 1, 0};
        tbl[6] = '{3, '1, 64'hFFFF_FEFF_FFFF_FFFF, 99, 0, 1'b0, 1, 40};

        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            st[g] = 1'b0; rdy[g] = 1'b1; ma[g] = '0; mb[g] = '0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) chk_zero(g);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            sweep(tbl[i].g, tbl[i].a, tbl[i].b, tbl[i].srow, tbl[i].sn,
                  tbl[i].mid, tbl[i].cnt, tbl[i].first);

        // Reset in the middle of a sweep, then a fresh sweep from row 0.
        @(negedge clk);
        ma[0] = 64'hFF; mb[0] = 64'h00; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        for (int c = 0; c < 12 && ri[0] != 6'd4; c++) @(negedge clk);
        chk("reach_row4", ri[0], 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero(0);
        rst_n = 1'b1;
        sweep(0, 64'hF0, 64'h3C, 99, 0, 1'b0, -1, -1);

        for (int r = 0; r < 12; r++) begin
            int g;
            logic [63:0] a, b;
            g = r % 4;
            a = {$urandom, $urandom};
            b = (r % 3 == 0) ? a : a ^ ({$urandom, $urandom} & {$urandom, $urandom});
            sweep(g, a, b, $urandom_range((1 << nof(g)) - 1, 0),
                  $urandom_range(2, 0), r[0], -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
